// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// I/O word indices, RAM depth and wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int IO_SW_IDX  = 126;
  localparam int IO_LED_IDX = 127;
  localparam int RAM_WORDS  = 126;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs (board switches).
module sync2 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake with WAIT_CYCLES wait states,
// 126-word RAM plus switch (word 126, read-only) and LED (word 127) I/O words.
// The memory operation happens at the clock edge that enters RESP, so rdata,
// led_out and perr are already valid during the single ack cycle.
// Optional build macro DMEM_PARITY_EN adds an even-parity bit to every RAM
// word and reports mismatches on perr alongside ack.
// The I/O decode assumes ADDRWIDTH = 8 (word indices 126/127).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATAWIDTH   = 16,
  parameter int ADDRWIDTH   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 ack,
  output logic                 busy,
  input  logic [2:0]           sw_in,
  output logic [DATAWIDTH-1:0] led_out,
  output logic                 perr
);

  localparam int IDX_W = ADDRWIDTH - 1;
`ifdef DMEM_PARITY_EN
  localparam int RAM_W = DATAWIDTH + 1;
`else
  localparam int RAM_W = DATAWIDTH;
`endif
  localparam logic [IDX_W-1:0] SW_IDX  = IDX_W'(IO_SW_IDX);
  localparam logic [IDX_W-1:0] LED_IDX = IDX_W'(IO_LED_IDX);
  localparam logic [IDX_W-1:0] RAM_TOP = IDX_W'(RAM_WORDS);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 lat_we;
  logic [IDX_W-1:0]     lat_idx;
  logic [DATAWIDTH-1:0] lat_wdata;
  logic [2:0]           sw_sync;
  logic [RAM_W-1:0]     ram [RAM_WORDS];

  // Operand actually used by the memory access; from the ports only when
  // WAIT_CYCLES = 0 and the access fires on the accept edge itself.
  logic                 op_fire;
  logic                 op_we;
  logic [IDX_W-1:0]     op_idx;
  logic [DATAWIDTH-1:0] op_wdata;
  logic                 op_ram;
  logic [RAM_W-1:0]     ram_wword;
  logic [RAM_W-1:0]     ram_rword;
  logic                 par_bad;

`ifdef DMEM_PARITY_EN
  function automatic logic even_par(input logic [DATAWIDTH-1:0] d);
    return ^d;
  endfunction

  assign ram_wword = {even_par(op_wdata), op_wdata};
  assign par_bad   = ram_rword[DATAWIDTH] ^ even_par(ram_rword[DATAWIDTH-1:0]);
`else
  assign ram_wword = op_wdata;
  assign par_bad   = 1'b0;
`endif

  assign op_ram    = (op_idx < RAM_TOP);
  assign ram_rword = ram[op_idx];
  assign ack       = (state == RESP);
  assign busy      = (state != IDLE);

  sync2 #(.WIDTH(3)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sw_sync)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic and selection of the operand for the firing access
  always_comb begin
    state_nxt = state;
    op_fire   = 1'b0;
    op_we     = lat_we;
    op_idx    = lat_idx;
    op_wdata  = lat_wdata;
    unique case (state)
      IDLE: begin
        op_we    = we;
        op_idx   = addr[ADDRWIDTH-1:1];
        op_wdata = wdata;
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            op_fire   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
          op_fire   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wait-state counter, loaded on accept and counted down in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     cnt <= '0;
    else if (state == IDLE && req)  cnt <= CNT_W'(WAIT_CYCLES);
    else if (state == WAIT)         cnt <= cnt - 1'b1;
  end

  // operand latch on accept; requester may drop or change inputs afterwards
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      lat_we    <= we;
      lat_idx   <= addr[ADDRWIDTH-1:1];
      lat_wdata <= wdata;
    end
  end

  // RAM write port; an access interrupted by reset never writes
  always_ff @(posedge clk) begin
    if (reset && op_fire && op_we && op_ram) ram[op_idx] <= ram_wword;
  end

  // load data, LED register and parity flag, all updated on the access edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata   <= '0;
      led_out <= '0;
      perr    <= 1'b0;
    end else if (op_fire) begin
      perr <= !op_we && op_ram && par_bad;
      if (op_we) begin
        if (op_idx == LED_IDX) led_out <= op_wdata;
      end else if (op_ram) begin
        rdata <= ram_rword[DATAWIDTH-1:0];
      end else if (op_idx == SW_IDX) begin
        rdata <= {{(DATAWIDTH-3){1'b0}}, sw_sync};
      end else begin
        rdata <= led_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes the expected
// response from a word-level memory model; a negedge monitor pops and
// checks data, perr, LED value and ack timing whenever ack is seen.
module tb_dmem_responder;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int WAIT_CYCLES = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;
  logic [2:0]    sw_in = 3'b000;
  logic [DW-1:0] led_out;
  logic          perr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    bit          chk_data;
    logic [15:0] data;
    bit          chk_perr;
    bit          perr;
    logic [15:0] led;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // reference model: word-level view of the memory map
  logic [15:0] m_mem [128];
  bit          m_known [128];
  bit          m_pbad [128];
  logic [15:0] m_led = '0;
  logic [2:0]  m_sw = 3'b000;

  dmem_responder #(
    .DATAWIDTH   (DW),
    .ADDRWIDTH   (AW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .busy    (busy),
    .sw_in   (sw_in),
    .led_out (led_out),
    .perr    (perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_cycle", cyc, mon_e.cyc);
        if (mon_e.chk_data) check("rdata", rdata, mon_e.data);
        if (mon_e.chk_perr) check("perr", perr, mon_e.perr);
        check("led_out", led_out, mon_e.led);
      end
    end
  end

  // issue one transaction and wait (bounded) for its ack
  task automatic run_op(input logic w, input logic [7:0] a, input logic [15:0] d, input bit drop);
    exp_t e;
    int   idx;
    bit   seen;
    idx = int'(a[7:1]);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    e.cyc = cyc + 1 + WAIT_CYCLES;
    e.chk_data = 1'b0; e.data = '0; e.chk_perr = 1'b1; e.perr = 1'b0;
    if (w) begin
      if (idx < 126) begin
        m_mem[idx] = d; m_known[idx] = 1'b1; m_pbad[idx] = 1'b0;
      end else if (idx == 127) begin
        m_led = d;
      end
    end else begin
      e.chk_data = 1'b1;
      if (idx < 126) begin
        e.data = m_mem[idx]; e.chk_data = m_known[idx];
        e.chk_perr = m_known[idx]; e.perr = m_pbad[idx];
      end else if (idx == 126) begin
        e.data = {13'b0, m_sw};
      end else begin
        e.data = m_led;
      end
    end
    e.led = m_led;
    exp_q.push_back(e);
    @(negedge clk);
    if (drop) begin
      req = 1'b0; we = 1'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (ack) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 40 cycles (addr=0x%0h)", a);
    end
    req = 1'b0;
  endtask

  task automatic set_sw(input logic [2:0] v);
    @(negedge clk);
    sw_in = v;
    m_sw = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] ra;
    for (int i = 0; i < 128; i++) begin
      m_mem[i] = '0; m_known[i] = 1'b0; m_pbad[i] = 1'b0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_led", led_out, 16'h0);
    check("rst_perr", perr, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // store then load, addr[0] ignored
    run_op(1'b1, 8'h10, 16'h1234, 1'b0);
    run_op(1'b0, 8'h10, 16'h0, 1'b0);
    run_op(1'b0, 8'h11, 16'h0, 1'b0);

    // LED and switch words
    run_op(1'b1, 8'hFE, 16'hBEEF, 1'b0);
    check("led_after_store", led_out, 16'hBEEF);
    run_op(1'b0, 8'hFF, 16'h0, 1'b0);
    set_sw(3'b101);
    run_op(1'b0, 8'hFC, 16'h0, 1'b0);
    run_op(1'b1, 8'hFC, 16'hAAAA, 1'b0);
    run_op(1'b0, 8'hFC, 16'h0, 1'b0);

    // reset during WAIT drops an in-flight store
    run_op(1'b1, 8'h20, 16'h1111, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 16'h5555;
    @(negedge clk);
    req = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_led", led_out, 16'h0);
    m_led = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_op(1'b0, 8'h20, 16'h0, 1'b0);

    // req dropped right after accept, garbage on the inputs afterwards
    run_op(1'b1, 8'h40, 16'hC0DE, 1'b1);
    run_op(1'b0, 8'h40, 16'h0, 1'b1);
    run_op(1'b1, 8'hFF, 16'h0F0F, 1'b1);

`ifdef DMEM_PARITY_EN
    run_op(1'b1, 8'h30, 16'h00F0, 1'b0);
    @(negedge clk);
    dut.ram[24][16] = ~dut.ram[24][16];
    m_pbad[24] = 1'b1;
    run_op(1'b0, 8'h30, 16'h0, 1'b0);
    run_op(1'b0, 8'hFC, 16'h0, 1'b0);
`endif

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) set_sw(3'($urandom));
      if ($urandom_range(0, 3) == 0) ra = 8'hFC + 8'($urandom_range(0, 3));
      else ra = 8'($urandom_range(0, 255));
      run_op(1'($urandom), ra, 16'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
